// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared constants and types for the FIR convolution sequencer.
//   - CONV_DATA_W / CONV_ACC_W / CONV_TAPS : default widths and kernel length
//   - conv_state_t                         : sequencer FSM state encoding
//   - CONV_SAT_MAX / CONV_SAT_MIN          : signed 16-bit clamp limits used
//                                            when CONV_SAT_EN is defined
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int CONV_DATA_W = 16;
    localparam int CONV_ACC_W  = 24;
    localparam int CONV_TAPS   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } conv_state_t;

    localparam logic signed [CONV_DATA_W-1:0] CONV_SAT_MAX = 16'sh7FFF;
    localparam logic signed [CONV_DATA_W-1:0] CONV_SAT_MIN = 16'sh8000;

endpackage

// File: rtl/conv_coef_bank.sv
// ---------------------------------------------------------------------------
// conv_coef_bank
//   TAPS x DATA_W coefficient register file. One synchronous write port and
//   one combinational read port addressed by the current tap index.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears all taps)
//     we         : write strobe (already qualified by the caller)
//     waddr      : tap index to write
//     wdata      : signed coefficient
//     raddr      : tap index to read
//     rdata      : signed coefficient at raddr
// ---------------------------------------------------------------------------
module conv_coef_bank #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 8,
    parameter int AW     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [DATA_W-1:0] rdata
);

    logic signed [DATA_W-1:0] h [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                h[i] <= '0;
            end
        end else if (we) begin
            h[waddr] <= wdata;
        end
    end

    assign rdata = h[raddr];

endmodule

// File: rtl/conv_mac_sequencer.sv
// ---------------------------------------------------------------------------
// conv_mac_sequencer
//   TAPS-tap FIR engine that time-shares one external 16-bit signed
//   multiplier. Each accepted sample shifts the delay line, then one multiply
//   per tap is issued over TAPS cycles, products are accumulated, and a single
//   16-bit result is offered on the output stream.
//
//   Configuration macro: CONV_SAT_EN
//     defined   : out_data is acc clamped to [-32768, 32767]
//     undefined : out_data is acc[DATA_W-1:0] (wraps)
//
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid/in_ready     : sample input handshake, in_sample = signed data
//     coef_we/addr/data     : coefficient write (honoured in IDLE only)
//     clr                   : delay-line clear (honoured in IDLE only)
//     mult_a/mult_b/mult_p  : external multiplier operands and low-half result
//     out_valid/out_ready   : result output handshake, out_data = result
//     busy                  : high while in MAC or OUT
//     dbg_state             : current FSM state for observation
//
//   Handshake semantics (both streams): a transfer happens on a rising edge
//   where valid and ready are both high. out_valid, once high, stays high with
//   out_data unchanged until that transfer; in_ready does not depend on
//   in_valid, and in_valid is ignored whenever in_ready is low.
// ---------------------------------------------------------------------------
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int  DATA_W = CONV_DATA_W,
    parameter int  TAPS   = CONV_TAPS,
    parameter int  ACC_W  = CONV_ACC_W,
    localparam int AW     = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [DATA_W-1:0] coef_data,
    input  logic                     clr,
    output logic signed [DATA_W-1:0] mult_a,
    output logic signed [DATA_W-1:0] mult_b,
    input  logic signed [DATA_W-1:0] mult_p,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output conv_state_t              dbg_state
);

    conv_state_t              state;
    conv_state_t              state_nxt;
    logic                     run;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            k;
    logic signed [DATA_W-1:0] h_k;
    logic signed [DATA_W-1:0] res;
    logic                     in_fire;
    logic                     last_tap;
    logic                     coef_wr;

    // run holds in_ready low for the whole reset assertion even though the
    // state register already reads IDLE; it sets on the first edge after
    // release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign last_tap = (k == AW'(TAPS - 1));
    assign coef_wr  = coef_we && (state == IDLE);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_fire)   state_nxt = MAC;
            MAC:     if (last_tap)  state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    assign dbg_state = state;
    assign busy      = (state != IDLE);
    assign in_ready  = run && (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_data  = (state == OUT) ? res : '0;
    assign mult_a    = (state == MAC) ? x[k] : '0;
    assign mult_b    = (state == MAC) ? h_k  : '0;

    // ------------------------------------------------------------------
    // Coefficients: written in IDLE only, read combinationally by k so a
    // write landing on the handshake edge is already visible at tap 0.
    // ------------------------------------------------------------------
    conv_coef_bank #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .AW     (AW)
    ) u_coef_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (coef_wr),
        .waddr  (coef_addr),
        .wdata  (coef_data),
        .raddr  (k),
        .rdata  (h_k)
    );

    // ------------------------------------------------------------------
    // Delay line, accumulator and tap counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
            acc <= '0;
            k   <= '0;
        end else begin
            if (state == IDLE) begin
                if (in_fire) begin
                    // clr in the same cycle leaves only the new sample.
                    x[0] <= in_sample;
                    for (int i = 1; i < TAPS; i++) begin
                        x[i] <= clr ? '0 : x[i-1];
                    end
                    acc <= '0;
                    k   <= '0;
                end else if (clr) begin
                    for (int i = 0; i < TAPS; i++) begin
                        x[i] <= '0;
                    end
                end
            end else if (state == MAC) begin
                // mult_p is signed, so the size cast sign-extends it.
                acc <= acc + ACC_W'(mult_p);
                k   <= last_tap ? '0 : k + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Result formatting
    // ------------------------------------------------------------------
`ifdef CONV_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(CONV_SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_LO = ACC_W'(CONV_SAT_MIN);

    always_comb begin
        res = acc[DATA_W-1:0];
        if (acc > ACC_HI) begin
            res = DATA_W'(CONV_SAT_MAX);
        end else if (acc < ACC_LO) begin
            res = DATA_W'(CONV_SAT_MIN);
        end
    end
`else
    assign res = acc[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_mac_sequencer
//   Directed and randomized bench for conv_mac_sequencer. The external
//   multiplier is modelled here as the low half of a signed product. The
//   reference keeps the delay line and kernel as plain integer arrays and
//   computes each result as a sum of wrapped products, then clamps or wraps
//   depending on CONV_SAT_EN.
// ---------------------------------------------------------------------------
module tb_conv_mac_sequencer;
    import conv_pkg::*;

    localparam int DATA_W = 16;
    localparam int TAPS   = 8;
    localparam int ACC_W  = 24;
    localparam int AW     = 3;

    // ---------------- clock / reset / DUT ----------------
    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_sample = '0;
    logic                     coef_we = 1'b0;
    logic [AW-1:0]            coef_addr = '0;
    logic signed [DATA_W-1:0] coef_data = '0;
    logic                     clr = 1'b0;
    logic signed [DATA_W-1:0] mult_a;
    logic signed [DATA_W-1:0] mult_b;
    logic signed [DATA_W-1:0] mult_p;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;
    conv_state_t              dbg_state;

    always #5 clk = ~clk;

    // 16-bit context: only the low half of the product survives.
    assign mult_p = mult_a * mult_b;

    conv_mac_sequencer #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clr       (clr),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int                tests = 0;
    int                fails = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                h_m [TAPS];
    int                x_m [TAPS];

    function automatic int wrap16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    function automatic int conv_expect();
        int s;
        s = 0;
        for (int t = 0; t < TAPS; t++) begin
            s += wrap16(x_m[t] * h_m[t]);
        end
`ifdef CONV_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return wrap16(s);
    endfunction

    task automatic model_reset();
        for (int t = 0; t < TAPS; t++) begin
            h_m[t] = 0;
            x_m[t] = 0;
        end
        exp_q.delete();
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (enter and leave at a negedge) ----------------
    task automatic write_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = DATA_W'(val);
        @(negedge clk);
        coef_we   = 1'b0;
        h_m[addr] = wrap16(val);
    endtask

    task automatic start_sample(input int s, input bit do_clr);
        check("in_ready_idle", in_ready, 1);
        check("mult_a_idle", mult_a, 0);
        in_valid  = 1'b1;
        in_sample = DATA_W'(s);
        clr       = do_clr;
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
        if (do_clr) begin
            for (int t = 0; t < TAPS; t++) x_m[t] = 0;
        end
        for (int t = TAPS - 1; t > 0; t--) x_m[t] = x_m[t-1];
        x_m[0] = wrap16(s);
        exp_q.push_back(DATA_W'(conv_expect()));
        // First MAC cycle: tap 0 operands on the multiplier.
        check("busy_mac", busy, 1);
        check("in_ready_mac", in_ready, 0);
        check("mult_a_tap0", mult_a, x_m[0]);
        check("mult_b_tap0", mult_b, h_m[0]);
    endtask

    task automatic wait_out();
        int lat;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, TAPS);
    endtask

    task automatic consume(output logic signed [DATA_W-1:0] got);
        logic [DATA_W-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        got = out_data;
        check("out_valid", out_valid, 1);
        check("out_data", out_data, $signed(e));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic send(input int s, input bit do_clr,
                        output logic signed [DATA_W-1:0] got);
        start_sample(s, do_clr);
        wait_out();
        consume(got);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic signed [DATA_W-1:0] got;
        logic signed [DATA_W-1:0] held;
        int                       seen;
        model_reset();

        // Reset: everything quiet while rst_n is low.
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mult_a", mult_a, 0);
        check("rst_mult_b", mult_b, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);

        // Identity kernel.
        write_coef(0, 1);
        send(1, 1'b0, got);   check("ident_1", got, 1);
        send(2, 1'b0, got);   check("ident_2", got, 2);
        send(515, 1'b0, got); check("ident_515", got, 515);

        // Two-tap kernel, fresh delay line.
        write_coef(0, -5);
        write_coef(1, -12);
        send(2, 1'b1, got);   check("two_tap_a", got, -10);
        send(515, 1'b0, got); check("two_tap_b", got, -2599);

        // Saturation / wrap with all-ones kernel.
        for (int t = 0; t < TAPS; t++) write_coef(t, 1);
        for (int i = 0; i < 8; i++) send(30000, (i == 0), got);
`ifdef CONV_SAT_EN
        check("sat_8th", got, 32767);
`else
        check("wrap_8th", got, -22144);
`endif

        // Backpressure: output held, coef write and input pulse ignored.
        start_sample(100, 1'b1);
        wait_out();
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, held);
            check("bp_in_ready", in_ready, 0);
            if (c == 1) begin
                coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd77;
            end
            if (c == 2) begin
                in_valid = 1'b1; in_sample = 16'sd999;
            end
            @(negedge clk);
            coef_we  = 1'b0;
            in_valid = 1'b0;
        end
        check("bp_held_value", held, 100);
        consume(got);
        send(50, 1'b0, got);  check("bp_after", got, 150);

        // Reset in the middle of MAC: no partial result.
        start_sample(7, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_mult_a", mult_a, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_out", seen, 0);
        write_coef(0, 1);
        send(214, 1'b0, got); check("after_rst_214", got, 214);

        // Randomized kernel and samples with random output stalls.
        for (int t = 0; t < TAPS; t++) write_coef(t, $urandom_range(0, 65535));
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                write_coef($urandom_range(0, TAPS - 1), $urandom_range(0, 65535));
            end
            start_sample($urandom_range(0, 65535), ($urandom_range(0, 5) == 0));
            wait_out();
            held = out_data;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rnd_stall_data", out_data, held);
            end
            consume(got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_mac_sequencer.md
# conv_mac_sequencer

Sequences the shared 16-bit signed multiplier (`multiplicacion`: `a`, `b` -> `sal`, combinational, low 16 bits of product) as a TAPS-tap FIR convolution engine. Per accepted input sample, the block shifts a delay line and issues one multiply per tap to the single multiplier instance. It accumulates the products and emits one saturated 16-bit result. It sits between the sample input stream and the convolution output stream of the processor.

## Interface
- `DATA_W`, 16: sample, coefficient and product width; fixed to match `multiplicacion`.
- `TAPS`, 8: kernel length; legal range 2..256.
- `ACC_W`, 24: accumulator width; must be ≥ DATA_W + clog2(TAPS).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`.
- `in_sample`  in  DATA_W  signed sample.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  clog2(TAPS)  tap index.
- `coef_data`  in  DATA_W  signed coefficient.
- `clr`  in  1  synchronous delay-line clear.
- `mult_a`  out  DATA_W  multiplier operand a (sample).
- `mult_b`  out  DATA_W  multiplier operand b (coefficient).
- `mult_p`  in  DATA_W  multiplier result `sal`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_data`  out  DATA_W  signed result.
- `busy`  out  1  high in MAC or OUT.

## Operation
- FSM states IDLE, MAC, OUT. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On handshake: x[k] <= x[k-1] for k ≥ 1, x[0] <= `in_sample`; acc <= 0; k <= 0; go to MAC.
- MAC:
  - `mult_a` = x[k], `mult_b` = h[k].
  - Each cycle: acc <= acc + sext(`mult_p`), k <= k+1.
  - After k = TAPS-1, go to OUT.
- OUT:
  - `out_valid` = 1, `out_data` = sat16(acc).
  - Output is held stable until `out_ready`, then go to IDLE.
- `mult_a`/`mult_b` are 0 outside MAC.
- Coefficient writes are honoured only in IDLE and ignored otherwise. They write h[`coef_addr`] <= `coef_data`.
- `clr` zeroes the whole delay line and is honoured only in IDLE. If `clr` and an input handshake occur in the same cycle, the delay line becomes {`in_sample`, 0, …}.
- `coef_we` together with an input handshake in IDLE: the write lands that edge, and the MAC uses the new coefficient.
- Products are taken as signed DATA_W; any wrap inside the multiplier is not corrected.
- The accumulator is signed ACC_W and cannot overflow within the legal parameter range.

## Timing
- Reset values:
  - `in_ready` = 0 while `rst_n` is low, 1 in IDLE after release.
  - `out_valid`, `out_data`, `mult_a`, `mult_b`, `busy` = 0.
  - Delay line, coefficients, acc and k = 0.
- Latency: handshake at edge 0; MAC occupies cycles 1..TAPS; `out_valid` is high from cycle TAPS+1.
- Throughput with `out_ready` = 1: one sample per TAPS+2 cycles.
- `in_ready` = 0 in MAC and OUT; `in_valid` is ignored there.
- Reset asserted mid-MAC or mid-OUT: immediate return to IDLE with all state cleared, and no partial result is emitted.

## Configuration
- `CONV_SAT_EN` defined: sat16 clamps acc to [-32768, 32767].
- `CONV_SAT_EN` undefined: `out_data` = acc[DATA_W-1:0], which wraps.

## Structure
- Package `conv_pkg`:
  - DATA_W/ACC_W constants.
  - State enum {IDLE, MAC, OUT}.
  - Saturation limits.
- One sub-module, `conv_coef_bank`: TAPS×DATA_W coefficient register file with write port and combinational read by k.
- `multiplicacion` is instantiated outside this block, at the level above, and connected via `mult_*`.

## Test plan
- Reset: hold `rst_n` = 0 -> all outputs 0. Release `rst_n` -> `in_ready` = 1 next cycle, `busy` = 0.
- Identity kernel: h = {1, 0, …}, samples 1, 2, 515 -> outputs 1, 2, 515. Each `out_valid` rises exactly TAPS+1 cycles after its handshake.
- Two-tap kernel: h0 = -5, h1 = -12, others 0. Samples 2 then 515 -> outputs -10 then -2599.
- Saturation, TAPS = 8: all h = 1, eight samples of 30000 -> eighth output is 32767 with `CONV_SAT_EN` and -22144 without.
- Backpressure: `out_ready` = 0 for 5 cycles in OUT -> `out_data` stable, `in_ready` = 0, a `coef_we` to h0 is ignored, and a pulsed `in_valid` is dropped.
- Reset mid-MAC: assert `rst_n` = 0 at MAC cycle 3 -> no `out_valid`. Reload h0 = 1 and send 214 -> output 214.
